// File: rtl/perf_counter_bank_if.sv
// Signal bundle between the core-side monitor logic and the performance counter bank.
// The counter bank connects through the slave modport.
interface perf_counter_bank_if #(
  parameter int NUM_EVENTS = 8,
  parameter int CNT_WIDTH  = 32,
  parameter int SEL_WIDTH  = 6
);
  logic                  perf_enable;
  logic                  clear;
  logic [NUM_EVENTS-1:0] event_vec;
  logic [31:0]           instr;
  logic [31:0]           pc;
  logic                  snap_req;
  logic [SEL_WIDTH-1:0]  rd_sel;
  logic [CNT_WIDTH-1:0]  rd_data;
  logic                  snap_valid;
  logic [CNT_WIDTH-1:0]  cycle_count;
  logic [NUM_EVENTS:0]   overflow;
  logic                  finished;
  logic                  finished_pulse;

  modport master (
    output perf_enable, clear, event_vec, instr, pc, snap_req, rd_sel,
    input  rd_data, snap_valid, cycle_count, overflow, finished, finished_pulse
  );

  modport slave (
    input  perf_enable, clear, event_vec, instr, pc, snap_req, rd_sel,
    output rd_data, snap_valid, cycle_count, overflow, finished, finished_pulse
  );
endinterface

// File: rtl/perf_counter_bank.sv
// Event/cycle counter bank with wrap or saturate arithmetic, program-finish detection
// and a shadow-register snapshot for coherent readout.
module perf_counter_bank #(
  parameter int NUM_EVENTS    = 8,
  parameter int CNT_WIDTH     = 32,
  parameter int FINISH_THRESH = 10,
  parameter bit SATURATE      = 1'b1,
  parameter int SEL_WIDTH     = 6
) (
  input logic                clk,
  input logic                rst,
  perf_counter_bank_if.slave bus
);
  localparam int NUM_CNT = NUM_EVENTS + 1;
  localparam int THR_W   = $clog2(FINISH_THRESH + 1);
  localparam logic [THR_W-1:0] THRESH = THR_W'(FINISH_THRESH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_reg, state_next;
  logic [CNT_WIDTH-1:0] cnt_live  [NUM_CNT];
  logic [CNT_WIDTH-1:0] shadow    [NUM_CNT];
  logic [NUM_CNT-1:0]   ovf_flags;
  logic [NUM_CNT-1:0]   inc;
  logic [THR_W-1:0]     zero_cnt_reg, zero_cnt_next;
  logic [THR_W-1:0]     stuck_cnt_reg, stuck_cnt_next;
  logic [31:0]          pc_prev_reg;
  logic                 snap_valid_reg;
  logic                 pulse_reg;
  logic                 run;
  logic                 go_done;
  logic                 capture;

  // Slot 0 is the cycle counter; slot i+1 follows event strobe i.
  assign run     = (state_reg == RUN) && !bus.clear;
  assign inc     = {bus.event_vec, 1'b1} & {NUM_CNT{run}};
  assign go_done = run && ((zero_cnt_next == THRESH) || (stuck_cnt_next == THRESH));
  assign capture = bus.snap_req || go_done;

  always_comb begin
    zero_cnt_next  = '0;
    stuck_cnt_next = '0;
    if (bus.instr == '0)
      zero_cnt_next = (zero_cnt_reg == THRESH) ? THRESH : zero_cnt_reg + 1'b1;
    if (bus.pc == pc_prev_reg)
      stuck_cnt_next = (stuck_cnt_reg == THRESH) ? THRESH : stuck_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (bus.clear) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (bus.perf_enable) state_next = RUN;
        RUN:     if (go_done) state_next = DONE;
                 else if (!bus.perf_enable) state_next = IDLE;
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.finished       = (state_reg == DONE);
    bus.finished_pulse = pulse_reg;
    bus.snap_valid     = snap_valid_reg;
    bus.cycle_count    = cnt_live[0];
    bus.overflow       = ovf_flags;
    bus.rd_data        = '0;
    for (int i = 0; i < NUM_CNT; i++)
      if (bus.rd_sel == SEL_WIDTH'(i)) bus.rd_data = shadow[i];
  end

  // Detector run lengths only advance in RUN and restart whenever the bank idles.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_cnt_reg   <= '0;
      stuck_cnt_reg  <= '0;
      pc_prev_reg    <= '0;
      pulse_reg      <= 1'b0;
      snap_valid_reg <= 1'b0;
    end else begin
      pc_prev_reg <= bus.pc;
      pulse_reg   <= go_done;
      if (capture) snap_valid_reg <= 1'b1;
      if (bus.clear || state_reg == IDLE) begin
        zero_cnt_reg  <= '0;
        stuck_cnt_reg <= '0;
      end else if (state_reg == RUN) begin
        zero_cnt_reg  <= zero_cnt_next;
        stuck_cnt_reg <= stuck_cnt_next;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
    logic [CNT_WIDTH-1:0] cnt_reg;
    logic [CNT_WIDTH-1:0] shadow_reg;
    logic                 ovf_reg;

    always_ff @(posedge clk) begin
      if (rst || bus.clear) begin
        cnt_reg <= '0;
        ovf_reg <= 1'b0;
      end else if (inc[gi]) begin
        if (&cnt_reg) begin
          ovf_reg <= 1'b1;
          if (!SATURATE) cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end

    // Shadows take the pre-edge live value, so a capture never sees this cycle's increment.
    always_ff @(posedge clk) begin
      if (rst)          shadow_reg <= '0;
      else if (capture) shadow_reg <= cnt_reg;
    end

    assign cnt_live[gi]  = cnt_reg;
    assign shadow[gi]    = shadow_reg;
    assign ovf_flags[gi] = ovf_reg;
  end
endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed/randomized bench for perf_counter_bank: a 32-bit saturating bank and two 4-bit
// banks (saturating and wrapping) share one stimulus stream and one reference model.
`timescale 1ns/1ps
module tb_perf_counter_bank;
  localparam int NE = 8;
  localparam int SW = 6;
  localparam int FT = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          pe, clr, snap;
  logic [NE-1:0] ev;
  logic [31:0]   ins, pcv;
  logic [SW-1:0] sel;

  always #50 clk = ~clk;

  perf_counter_bank_if #(.NUM_EVENTS(NE), .CNT_WIDTH(32), .SEL_WIDTH(SW)) bus_a ();
  perf_counter_bank_if #(.NUM_EVENTS(NE), .CNT_WIDTH(4),  .SEL_WIDTH(SW)) bus_b ();
  perf_counter_bank_if #(.NUM_EVENTS(NE), .CNT_WIDTH(4),  .SEL_WIDTH(SW)) bus_c ();

  assign bus_a.perf_enable = pe;  assign bus_b.perf_enable = pe;  assign bus_c.perf_enable = pe;
  assign bus_a.clear = clr;       assign bus_b.clear = clr;       assign bus_c.clear = clr;
  assign bus_a.event_vec = ev;    assign bus_b.event_vec = ev;    assign bus_c.event_vec = ev;
  assign bus_a.instr = ins;       assign bus_b.instr = ins;       assign bus_c.instr = ins;
  assign bus_a.pc = pcv;          assign bus_b.pc = pcv;          assign bus_c.pc = pcv;
  assign bus_a.snap_req = snap;   assign bus_b.snap_req = snap;   assign bus_c.snap_req = snap;
  assign bus_a.rd_sel = sel;      assign bus_b.rd_sel = sel;      assign bus_c.rd_sel = sel;

  perf_counter_bank #(.NUM_EVENTS(NE), .CNT_WIDTH(32), .FINISH_THRESH(FT), .SATURATE(1'b1), .SEL_WIDTH(SW))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  perf_counter_bank #(.NUM_EVENTS(NE), .CNT_WIDTH(4), .FINISH_THRESH(FT), .SATURATE(1'b1), .SEL_WIDTH(SW))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  perf_counter_bank #(.NUM_EVENTS(NE), .CNT_WIDTH(4), .FINISH_THRESH(FT), .SATURATE(1'b0), .SEL_WIDTH(SW))
    dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  // Reference model: true (unbounded) event totals since the last clear; the visible
  // counter value is derived from the total by the width and the wrap/saturate rule.
  int          mode;          // 0 = idle, 1 = running, 2 = finished
  longint      m_cyc;
  longint      m_ev [NE];
  longint      sh_cyc;
  longint      sh_ev [NE];
  int          zrun, srun;
  logic [31:0] pc_prev;
  bit          sv, pulse;
  int          n_vec, n_bad;
  logic [31:0] pcs;

  function automatic longint exp_val(longint total, int w, bit sat);
    longint lim = longint'(1) << w;
    if (total < lim) return total;
    return sat ? lim - 1 : total % lim;
  endfunction

  function automatic logic [63:0] exp_ovf(int w);
    logic [63:0] v = '0;
    longint lim = longint'(1) << w;
    v[0] = (m_cyc >= lim);
    for (int i = 0; i < NE; i++) v[i+1] = (m_ev[i] >= lim);
    return v;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    mode = 0; m_cyc = 0; sh_cyc = 0; zrun = 0; srun = 0; pc_prev = '0; sv = 0; pulse = 0;
    for (int i = 0; i < NE; i++) begin m_ev[i] = 0; sh_ev[i] = 0; end
  endtask

  task automatic model_edge();
    int zn, sn;
    bit fin;
    zn  = (ins == 32'd0) ? ((zrun < FT) ? zrun + 1 : FT) : 0;
    sn  = (pcv == pc_prev) ? ((srun < FT) ? srun + 1 : FT) : 0;
    fin = (mode == 1) && !clr && (zn == FT || sn == FT);
    if (snap || fin) begin
      sh_cyc = m_cyc;
      for (int i = 0; i < NE; i++) sh_ev[i] = m_ev[i];
      sv = 1;
    end
    pulse = fin;
    if (clr) begin
      m_cyc = 0; zrun = 0; srun = 0; mode = 0;
      for (int i = 0; i < NE; i++) m_ev[i] = 0;
    end else if (mode == 0) begin
      zrun = 0; srun = 0;
      if (pe) mode = 1;
    end else if (mode == 1) begin
      m_cyc++;
      for (int i = 0; i < NE; i++) if (ev[i]) m_ev[i]++;
      zrun = zn; srun = sn;
      if (fin) mode = 2;
      else if (!pe) mode = 0;
    end
    pc_prev = pcv;
  endtask

  task automatic check_live();
    chk("cycle_count_a32", 64'(bus_a.cycle_count), exp_val(m_cyc, 32, 1));
    chk("cycle_count_b4sat", 64'(bus_b.cycle_count), exp_val(m_cyc, 4, 1));
    chk("cycle_count_c4wrap", 64'(bus_c.cycle_count), exp_val(m_cyc, 4, 0));
    chk("overflow_a32", 64'(bus_a.overflow), exp_ovf(32));
    chk("overflow_b4sat", 64'(bus_b.overflow), exp_ovf(4));
    chk("overflow_c4wrap", 64'(bus_c.overflow), exp_ovf(4));
    chk("finished", 64'(bus_a.finished), 64'(mode == 2));
    chk("finished_pulse", 64'(bus_a.finished_pulse), 64'(pulse));
    chk("snap_valid", 64'(bus_c.snap_valid), 64'(sv));
  endtask

  task automatic check_read();
    int sels[12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 37, 63};
    foreach (sels[j]) begin
      longint t;
      bit     hit;
      sel = SW'(sels[j]);
      #1;
      hit = (sels[j] <= NE);
      if (sels[j] == 0) t = sh_cyc;
      else if (hit)     t = sh_ev[sels[j] - 1];
      else              t = 0;
      chk($sformatf("rd_data_a32_sel%0d", sels[j]), 64'(bus_a.rd_data), hit ? exp_val(t, 32, 1) : 0);
      chk($sformatf("rd_data_b4sat_sel%0d", sels[j]), 64'(bus_b.rd_data), hit ? exp_val(t, 4, 1) : 0);
      chk($sformatf("rd_data_c4wrap_sel%0d", sels[j]), 64'(bus_c.rd_data), hit ? exp_val(t, 4, 0) : 0);
    end
  endtask

  task automatic step(bit p, bit c, logic [NE-1:0] e, logic [31:0] i, logic [31:0] pc_in, bit s);
    pe = p; clr = c; ev = e; ins = i; pcv = pc_in; snap = s;
    @(posedge clk);
    model_edge();
    #1;
    check_live();
  endtask

  function automatic logic [31:0] nz_instr();
    return $urandom() | 32'd1;
  endfunction

  initial begin
    n_vec = 0; n_bad = 0; pcs = 32'h1000;
    rst = 1'b1; pe = 0; clr = 0; ev = '0; ins = '0; pcv = '0; snap = 0; sel = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_live();
    check_read();
    rst = 1'b0;

    // 20 enabled cycles with events 0 and 2; snapshot on the 7th running cycle.
    for (int k = 0; k < 20; k++) begin
      pcs += 4;
      step(1, 0, 8'b0000_0101, nz_instr(), pcs, k == 7);
    end
    check_read();
    pcs += 4; step(0, 0, 8'b0000_0101, nz_instr(), pcs, 1'b0);
    pcs += 4; step(0, 0, '0, nz_instr(), pcs, 1'b1);
    check_read();

    // Zero instructions from the 5th running cycle until the finish threshold trips.
    pcs += 4; step(0, 1, '0, nz_instr(), pcs, 1'b0);
    for (int k = 0; k < 22; k++) begin
      pcs += 4;
      step(1, 0, NE'($urandom()), (k >= 5) ? 32'd0 : nz_instr(), pcs, 1'b0);
    end
    check_read();

    // In the finished state: clear, snapshot and enable together.
    pcs += 4; step(1, 1, '1, nz_instr(), pcs, 1'b1);
    check_read();
    for (int k = 0; k < 6; k++) begin
      pcs += 4;
      step(1, 0, NE'($urandom()), nz_instr(), pcs, k == 5);
    end
    check_read();

    // Stuck PC: broken after 8 qualifying cycles, then held until it finishes.
    pcs += 4; step(1, 1, '0, nz_instr(), pcs, 1'b0);
    pcs += 4;
    for (int k = 0; k < 26; k++) begin
      if (k == 9) pcs += 4;
      step(1, 0, NE'($urandom()), nz_instr(), pcs, 1'b0);
    end
    check_read();

    // Threshold completes in the same cycle perf_enable drops.
    pcs += 4; step(0, 1, '0, nz_instr(), pcs, 1'b0);
    for (int k = 0; k < 14; k++) begin
      pcs += 4;
      step(k != 10, 0, NE'($urandom()), (k >= 1) ? 32'd0 : nz_instr(), pcs, 1'b0);
    end
    check_read();

    // Randomized traffic with dense events so the narrow banks overflow.
    pcs += 4; step(0, 1, '0, nz_instr(), pcs, 1'b0);
    for (int k = 0; k < 240; k++) begin
      logic [NE-1:0] e;
      e = NE'($urandom()) | NE'($urandom());
      if ($urandom_range(0, 3) != 0) pcs += 4;
      step($urandom_range(0, 7) != 0, $urandom_range(0, 59) == 0, e,
           ($urandom_range(0, 2) == 0) ? 32'd0 : nz_instr(), pcs, $urandom_range(0, 9) == 0);
      if (k % 30 == 29) check_read();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
Parametrised performance-monitoring block. It replaces the fixed per-metric counters and the hard-coded program-finish detector inside the core. It counts NUM_EVENTS single-bit event strobes plus a cycle counter, with selectable wrap or saturate arithmetic and sticky overflow flags. It detects program completion with a configurable threshold and provides a coherent snapshot/readout port for the testbench or a future CSR interface. It sits beside the core pipeline; event strobes come from IF..WB, and instr/pc come from the IF stage.

Parameters:
NUM_EVENTS, 8, number of event counter channels (1..32)
CNT_WIDTH, 32, width of every counter, including the cycle counter (4..64)
FINISH_THRESH, 10, consecutive qualifying cycles that declare the program finished (>=1)
SATURATE, 1, 1 = counters stick at all-ones; 0 = counters wrap to 0
SEL_WIDTH, 6, width of rd_sel; must satisfy 2^SEL_WIDTH > NUM_EVENTS

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
perf_enable  input  1  counting enable
clear  input  1  synchronous soft clear of live state
event_vec  input  NUM_EVENTS  event strobes; bit i increments counter i
instr  input  32  IF-stage instruction word
pc  input  32  IF-stage PC
snap_req  input  1  capture live counters into shadow registers
rd_sel  input  SEL_WIDTH  readout select
rd_data  output  CNT_WIDTH  selected shadow value (combinational)
snap_valid  output  1  shadow registers hold a valid snapshot
cycle_count  output  CNT_WIDTH  live cycle counter
overflow  output  NUM_EVENTS+1  sticky overflow flags; bit 0 = cycle counter, bit i+1 = event i
finished  output  1  sticky program-finished flag
finished_pulse  output  1  one-cycle strobe on entry to DONE

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. rst has priority over everything.
- Reset state: state=IDLE; all live counters, shadows, overflow, zero_cnt, stuck_cnt and pc_prev = 0; snap_valid=0; finished=0; finished_pulse=0.
- FSM:
  - IDLE -> RUN when perf_enable=1.
  - RUN -> IDLE when perf_enable=0. Live counters hold their values.
  - RUN -> DONE on the edge where zero_cnt or stuck_cnt reaches FINISH_THRESH.
  - DONE is sticky; it is left only via rst or clear.
- RUN counting:
  - cycle_count increments by 1 on every RUN cycle, including the cycle that completes the finish threshold.
  - Counter i increments by 1 when event_vec[i]=1.
  - IDLE and DONE never count.
- Arithmetic:
  - Increment of a counter at all-ones sets its overflow bit. The bit is sticky until rst/clear.
  - SATURATE=1: the value stays at all-ones.
  - SATURATE=0: the value becomes 0.
- Finish detection, active only in RUN:
  - zero_cnt increments while instr==0 and resets to 0 otherwise.
  - stuck_cnt increments while pc==pc_prev and resets to 0 otherwise.
  - Both saturate at FINISH_THRESH and are cleared in IDLE.
  - pc_prev <= pc every cycle in all states.
  - With FINISH_THRESH=N, the Nth consecutive qualifying RUN cycle causes finished=1 and finished_pulse=1 in the following cycle.
- Snapshot:
  - On an edge with snap_req=1, or on the RUN->DONE edge, every shadow register loads the live value present before that edge (pre-increment).
  - snap_valid=1 from the next cycle; it is cleared only by rst.
  - snap_req in DONE re-captures the frozen values.
- Readout:
  - rd_sel=0 returns the cycle shadow.
  - rd_sel=1..NUM_EVENTS returns the event shadow rd_sel-1.
  - Any other rd_sel returns 0.
- clear:
  - Zeroes live counters, overflow, zero_cnt, stuck_cnt, finished and finished_pulse; state -> IDLE.
  - It does not touch shadows, snap_valid or pc_prev.
  - clear beats counting in the same cycle; no increment occurs.
  - snap_req together with clear captures the pre-clear values.
  - perf_enable=1 with clear gives state IDLE next cycle, then RUN one cycle later.
- Simultaneous events: any number of event_vec bits may be set in the same cycle. Each counter is independent, with at most +1 per cycle.
- perf_enable dropping in the same cycle a threshold completes: that cycle counts, and DONE takes priority over IDLE.

Test Plan:
- Reset, then perf_enable=1 for 20 cycles with event_vec=8'b0000_0101 every cycle and instr/pc non-repeating -> cycle_count=20, counters 0 and 2 =20, others 0, finished=0.
- snap_req on cycle 7 of RUN, then read with rd_sel=0,1,2,9 -> 6 (pre-increment), 6, 0, 0; snap_valid=1 from the next cycle.
- instr=0 held from RUN cycle 5 with FINISH_THRESH=10 -> finished_pulse high exactly one cycle, 10 cycles after the first zero; cycle_count frozen at 14; shadows equal the frozen values; finished stays 1.
- pc held constant for 10 cycles in RUN, with a pc change at qualifying cycle 9 -> no finish; a subsequent 10 constant cycles -> finished=1.
- CNT_WIDTH=4, SATURATE=1, event 0 for 20 cycles -> counter=15, overflow[1]=1. With SATURATE=0 -> counter=4 (20 mod 16), overflow[1]=1.
- In DONE assert clear+snap_req with perf_enable=1 -> shadows hold pre-clear values; live counters=0; finished=0; IDLE for one cycle, then counting resumes.
